fp_mul_arbiter: RTL and testbench

Shares one multi-cycle fpMultiplier instance among NUM_REQ requesters. Each requester has a valid/ready request port. The block arbitrates round-robin, drives the multiplier's enable/in1/in2 for a fixed latency, captures out/overflow, and returns the result on a single tagged response channel. It sits between the client blocks and the fpMultiplier instance, one level above it.

---
 rtl/fp_mul_pkg.sv | 19 +
 rtl/rr_picker.sv | 35 +++
 rtl/fp_mul_arbiter.sv | 147 ++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the fpMultiplier arbiter: data width, default
// multiplier latency and the arbiter state encoding.
package fp_mul_pkg;

  localparam int FP_W            = 32;
  localparam int MUL_LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Index width for an N-entry vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N; returns a one-hot grant and its binary index.
module rr_picker
  import fp_mul_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  int   w_pos;
  logic w_hit;
  logic w_found;

  // Search offsets 1..N from the pointer so the last winner ranks lowest.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_pos   = 0;
    w_hit   = 1'b0;
    w_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      w_pos        = (int'(i_ptr) + i) % N;
      w_hit        = i_req[w_pos] & ~w_found;
      o_gnt[w_pos] = w_hit;
      o_idx        = w_hit ? IW'(w_pos) : o_idx;
      w_found      = w_found | w_hit;
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one multi-cycle fpMultiplier among NUM_REQ clients,
// returning each product on a single id-tagged response channel.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [FP_W*NUM_REQ-1:0] req_in1,
  input  logic [FP_W*NUM_REQ-1:0] req_in2,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_data,
  output logic                    rsp_overflow,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    mul_enable,
  output logic [FP_W-1:0]         mul_in1,
  output logic [FP_W-1:0]         mul_in2,
  input  logic [FP_W-1:0]         mul_out,
  input  logic                    mul_overflow,
  output logic                    busy
);

  localparam logic [3:0] LAST_CNT = 4'(MUL_LATENCY - 1);

  state_e              r_state;
  state_e              w_next_state;
  logic [3:0]          r_cnt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_rsp_id;
  logic [FP_W-1:0]     r_op1;
  logic [FP_W-1:0]     r_op2;
  logic [FP_W-1:0]     r_rsp_data;
  logic                r_rsp_ovf;
  logic                r_rsp_valid;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_idx;
  logic [FP_W-1:0]     w_sel1;
  logic [FP_W-1:0]     w_sel2;
  logic                w_accept;
  logic                w_last;

  rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_picker (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_sel1   = req_in1[int'(w_idx) * FP_W +: FP_W];
  assign w_sel2   = req_in2[int'(w_idx) * FP_W +: FP_W];
  assign w_accept = (r_state == ST_IDLE) && (|w_gnt);
  assign w_last   = (r_state == ST_BUSY) && (r_cnt == LAST_CNT);

  // Grants are visible only in IDLE and are forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if ((r_state == ST_IDLE) && !reset) begin
      req_ready = w_gnt;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_BUSY;
        else          w_next_state = ST_IDLE;
      end
      ST_BUSY: begin
        if (w_last) w_next_state = ST_RESP;
        else        w_next_state = ST_BUSY;
      end
      ST_RESP: begin
        if (rsp_ready) w_next_state = ST_IDLE;
        else           w_next_state = ST_RESP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, job capture and result registers; operands clear when BUSY ends
  // so the multiplier inputs read zero whenever enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op1    <= w_sel1;
            r_op2    <= w_sel2;
            r_id     <= w_idx;
            r_rr_ptr <= w_idx;
            r_cnt    <= 4'd0;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_rsp_data  <= mul_out;
            r_rsp_ovf   <= mul_overflow;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_op1       <= '0;
            r_op2       <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mul_enable   = (r_state == ST_BUSY);
  assign mul_in1      = r_op1;
  assign mul_in2      = r_op2;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_overflow = r_rsp_ovf;
  assign rsp_id       = r_rsp_id;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural fpMultiplier whose
// output is only meaningful in the last enable cycle of a job.
module tb_fp_mul_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int L  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_in1;
  logic [32*N-1:0] req_in2;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic            rsp_overflow;
  logic [IW-1:0]   rsp_id;
  logic            mul_enable;
  logic [31:0]     mul_in1;
  logic [31:0]     mul_in2;
  logic [31:0]     mul_out;
  logic            mul_overflow;
  logic            busy;

  fp_mul_arbiter #(.NUM_REQ(N), .ID_W(IW), .MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_in1(req_in1),
    .req_in2(req_in2), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
    .rsp_id(rsp_id), .mul_enable(mul_enable), .mul_in1(mul_in1),
    .mul_in2(mul_in2), .mul_out(mul_out), .mul_overflow(mul_overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Known products from the test plan; other operand pairs map to a ^ b.
  function automatic logic [32:0] mdl(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40aa6666, 32'h40aa6666}: return {1'b0, 32'h41e2d850};
      {32'hc0080000, 32'hc0680000}: return {1'b0, 32'h40f68000};
      {32'hbf200000, 32'h3fd00000}: return {1'b0, 32'hbf820000};
      {32'h40a80000, 32'hc0440000}: return {1'b0, 32'hc180a000};
      {32'h3f800000, 32'h40480000}: return {1'b0, 32'h40480000};
      {32'h7f000000, 32'h7f000000}: return {1'b1, 32'h3e800000};
      {32'h00000000, 32'h40a80000}: return {1'b0, 32'h00000000};
      default:                      return {1'b0, a ^ b};
    endcase
  endfunction

  int          en_cnt = 0;
  logic [32:0] mdl_res;

  always @(posedge clk) begin
    if (reset || !mul_enable) en_cnt <= 0;
    else                      en_cnt <= en_cnt + 1;
  end

  always_comb begin
    mdl_res = mdl(mul_in1, mul_in2);
    if (mul_enable && (en_cnt == L - 1)) begin
      mul_out      = mdl_res[31:0];
      mul_overflow = mdl_res[32];
    end else begin
      mul_out      = 32'hbad0bad0;
      mul_overflow = 1'b1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  int          cyc = 0, acc_cyc = 0, rise_cyc = 0, run = 0, r13 = 0;
  int          acc_cnt [N];
  int          target  [N];
  int          gnt_log [64];
  int          gnt_n = 0;
  logic [31:0] rd_log  [64];
  logic        ro_log  [64];
  int          rid_log [64];
  int          rsp_n = 0;
  logic        prev_rv = 1'b0;

  // Rising-edge monitor: handshakes, response log, enable run length.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (reset) begin
      run = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_cnt[i]++;
          gnt_log[gnt_n] = i;
          gnt_n++;
          acc_cyc = cyc;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rd_log[rsp_n]  = rsp_data;
        ro_log[rsp_n]  = rsp_overflow;
        rid_log[rsp_n] = int'(rsp_id);
        rsp_n++;
      end
      if (mul_enable) run++;
      else if (run != 0) begin
        chk("enable_len", run, L);
        run = 0;
      end
    end
  end

  // Falling-edge monitor: response rise time and idle-time invariants.
  initial forever begin
    @(negedge clk);
    if (rsp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = rsp_valid;
    if (!reset) begin
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (req_ready[1] || req_ready[3]) r13++;
      if (!mul_enable) begin
        chk("mul_in1_idle", mul_in1, 32'd0);
        chk("mul_in2_idle", mul_in2, 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_in1[i*32 +: 32] = a;
    req_in2[i*32 +: 32] = b;
  endtask

  task automatic update_valids();
    for (int i = 0; i < N; i++) req_valid[i] = (acc_cnt[i] < target[i]);
  endtask

  function automatic bit all_met();
    for (int i = 0; i < N; i++) if (acc_cnt[i] < target[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_until_idle(input string nm, input int budget);
    int t;
    for (t = 0; t < budget; t++) begin
      @(negedge clk);
      update_valids();
      if (all_met() && !busy && !rsp_valid) break;
    end
    if (t == budget) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout after %0d cycles, expected idle", nm, budget);
    end
  endtask

  task automatic wait_accept(input int i, input int budget);
    int t;
    for (t = 0; t < budget; t++) begin
      @(negedge clk);
      update_valids();
      if (acc_cnt[i] >= target[i]) break;
    end
    if (t == budget) begin
      tests++;
      fails++;
      $display("FAIL accept_wait: requester %0d not granted in %0d cycles", i, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        o;
  } vec_t;

  vec_t vt [5];
  int   s, gs, r13s;

  initial begin
    vt[0] = '{0, 32'h40aa6666, 32'h40aa6666, 32'h41e2d850, 1'b0};
    vt[1] = '{3, 32'h7f000000, 32'h7f000000, 32'h3e800000, 1'b1};
    vt[2] = '{3, 32'h00000000, 32'h40a80000, 32'h00000000, 1'b0};
    vt[3] = '{1, 32'hbf200000, 32'h3fd00000, 32'hbf820000, 1'b0};
    vt[4] = '{2, 32'h40a80000, 32'hc0440000, 32'hc180a000, 1'b0};

    reset = 1'b1; rsp_ready = 1'b1;
    req_valid = '1; req_in1 = '0; req_in2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(req_ready), 32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",   rsp_data, 32'd0);
    chk("rst_rsp_ovf",    32'(rsp_overflow), 32'd0);
    chk("rst_rsp_id",     32'(rsp_id), 32'd0);
    chk("rst_mul_enable", 32'(mul_enable), 32'd0);
    chk("rst_mul_in1",    mul_in1, 32'd0);
    chk("rst_mul_in2",    mul_in2, 32'd0);
    chk("rst_busy",       32'(busy), 32'd0);
    req_valid = '0;
    reset = 1'b0;

    // Single-requester jobs from the vector table.
    for (int v = 0; v < 5; v++) begin
      s = rsp_n;
      set_ops(vt[v].idx, vt[v].a, vt[v].b);
      target[vt[v].idx]++;
      drive_until_idle("vec_job", 40);
      chk("vec_rsp_count", rsp_n - s, 1);
      chk("vec_data", rd_log[s], vt[v].d);
      chk("vec_ovf",  32'(ro_log[s]), 32'(vt[v].o));
      chk("vec_id",   rid_log[s], vt[v].idx);
      chk("vec_latency", rise_cyc - acc_cyc, L);
    end

    // All four requesters valid right after reset.
    do_reset();
    set_ops(0, 32'hc0080000, 32'hc0680000);
    set_ops(1, 32'hbf200000, 32'h3fd00000);
    set_ops(2, 32'h40a80000, 32'hc0440000);
    set_ops(3, 32'h3f800000, 32'h40480000);
    gs = gnt_n; s = rsp_n;
    for (int i = 0; i < N; i++) target[i]++;
    drive_until_idle("all_four", 100);
    for (int k = 0; k < N; k++) begin
      chk("all4_grant", gnt_log[gs+k], k);
      chk("all4_id",    rid_log[s+k], k);
    end
    chk("all4_data0", rd_log[s],   32'h40f68000);
    chk("all4_data1", rd_log[s+1], 32'hbf820000);
    chk("all4_data2", rd_log[s+2], 32'hc180a000);
    chk("all4_data3", rd_log[s+3], 32'h40480000);

    // Requesters 0 and 2 continuously valid for six jobs.
    set_ops(0, 32'h12345678, 32'h0f0f0f0f);
    set_ops(2, 32'ha5a5a5a5, 32'h0000ffff);
    gs = gnt_n; s = rsp_n; r13s = r13;
    target[0] += 3; target[2] += 3;
    drive_until_idle("alt_02", 150);
    chk("alt_count", gnt_n - gs, 6);
    for (int k = 0; k < 6; k++) begin
      chk("alt_grant", gnt_log[gs+k], (k % 2 == 0) ? 0 : 2);
      chk("alt_data",  rd_log[s+k],
          (k % 2 == 0) ? (32'h12345678 ^ 32'h0f0f0f0f) : (32'ha5a5a5a5 ^ 32'h0000ffff));
    end
    chk("alt_no_ready_13", r13 - r13s, 0);

    // Response backpressure with other requests pending.
    s = rsp_n;
    rsp_ready = 1'b0;
    set_ops(1, 32'h3f800000, 32'h40480000);
    target[1]++;
    wait_accept(1, 20);
    target[0]++; target[2]++;
    for (int t = 0; t < 20 && !rsp_valid; t++) begin
      @(negedge clk);
      update_valids();
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      update_valids();
      chk("bp_data",  rsp_data, 32'h40480000);
      chk("bp_ovf",   32'(rsp_overflow), 32'd0);
      chk("bp_id",    32'(rsp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_enable", 32'(mul_enable), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
    end
    gs = gnt_n;
    rsp_ready = 1'b1;
    drive_until_idle("bp_resume", 100);
    chk("bp_rsp_count", rsp_n - s, 3);
    chk("bp_first_id", rid_log[s], 1);
    chk("bp_grant_a", gnt_log[gs], 2);
    chk("bp_grant_b", gnt_log[gs+1], 0);

    // Reset during the second BUSY cycle aborts the job.
    do_reset();
    set_ops(0, 32'h40aa6666, 32'h40aa6666);
    target[0]++;
    wait_accept(0, 20);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    s = rsp_n;
    reset = 1'b1;
    #1;
    chk("abort_enable", 32'(mul_enable), 32'd0);
    chk("abort_busy",   32'(busy), 32'd0);
    chk("abort_valid",  32'(rsp_valid), 32'd0);
    chk("abort_in1",    mul_in1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_ops(0, 32'hc0080000, 32'hc0680000);
    set_ops(1, 32'hbf200000, 32'h3fd00000);
    gs = gnt_n;
    target[0]++; target[1]++;
    drive_until_idle("after_abort", 100);
    chk("abort_rsp_count", rsp_n - s, 2);
    chk("abort_grant0", gnt_log[gs], 0);
    chk("abort_grant1", gnt_log[gs+1], 1);
    chk("abort_data0",  rd_log[s], 32'h40f68000);
    chk("abort_id0",    rid_log[s], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
